spectrum_bar_renderer: RTL and testbench
========================================

// Module: spectrum_bar_renderer
// PURPOSE
// - Consumes the smoothed per-bin levels held by the exponential spectrum filter and renders them as a bar graph.
// - Each start pulse sweeps bins 0..NUM_BINS-1 through the filter's read address and emits one GRB pixel stream frame.
// - The pixel stream feeds the LED-strip serialiser over a valid/ready handshake.
// PARAMETERS
// - NUM_BINS      40         number of spectrum bins / bars
// - LEVEL_W       8          bin level width
// - LEDS_PER_BAR  8          pixels per bar (2..15)
// - SERPENTINE    1          1: odd-numbered bars are emitted top-to-bottom
// - COLOR_LOW     24'hFF0000 GRB for lit pixels below 3/4 bar height (green)
// - COLOR_HIGH    24'h00FF00 GRB for lit pixels at or above 3/4 height (red)
// - COLOR_PEAK    24'hFFFFFF GRB for the peak-hold marker
// - PEAK_FALL     4          frames per 1-pixel peak fall
// PORTS
// - clk         in   1        clock
// - rst         in   1        reset, asynchronous, active-high
// - start       in   1        1-cycle pulse; begins a frame when idle
// - bin_addr    out  8        read address to the filter bins
// - bin_level   in   LEVEL_W  filter output for bin_addr; sampled 1 cycle after bin_addr changes
// - pix_data    out  24       GRB pixel
// - pix_valid   out  1        pix_data is valid
// - pix_ready   in   1        sink accepts pix_data when pix_valid & pix_ready
// - pix_last    out  1        qualifies the final pixel of a frame
// - busy        out  1        high from the cycle after an accepted start until frame_done
// - frame_done  out  1        1-cycle pulse after the last pixel is accepted
// BEHAVIOUR
// - Reset values: bin_addr=0, pix_data=0, pix_valid=0, pix_last=0, busy=0, frame_done=0, state=IDLE; all peak registers=0.
// - FSM states: IDLE -> ADDR -> LOAD -> EMIT -> (ADDR | DONE) -> IDLE.
// - IDLE: start=1 -> ADDR, with bin counter b=0. A start received while not in IDLE is ignored (no queueing).
// - ADDR: drive bin_addr=b; hold it for one cycle.
// - LOAD: latch bin_level; compute h=((level+1)*LEDS_PER_BAR)>>LEVEL_W.
//   - Examples with 8 LEDs: level 0 -> h=0; level 128 -> h=4; level 255 -> h=8.
//   - Use a LEVEL_W+4-bit intermediate; no overflow.
// - EMIT: pixel counter p runs 0..LEDS_PER_BAR-1; physical row j=p, or j=LEDS_PER_BAR-1-p when SERPENTINE and b is odd.
//   - j<h: pixel lit. Colour is COLOR_HIGH if 4*j >= 3*LEDS_PER_BAR, else COLOR_LOW.
//   - j>=h: pixel is 0, except for the peak marker.
// - Handshake: pix_valid rises the cycle after LOAD.
//   - pix_data and pix_last hold stable while pix_valid=1 & pix_ready=0.
//   - One pixel transfers per cycle when pix_ready is held high; no bubble between pixels of a bar.
//   - There is a 2-cycle bubble (ADDR, LOAD) between bars.
// - pix_last=1 only for b=NUM_BINS-1, p=LEDS_PER_BAR-1.
// - Transfer of the last pixel of a bar: b<NUM_BINS-1 -> b+1 and ADDR; otherwise -> DONE.
// - DONE: frame_done=1 for one cycle, busy falls the same cycle, next state IDLE.
// - Frame length: NUM_BINS*LEDS_PER_BAR pixels (320 at defaults).
// - A pix_ready asserted without pix_valid is ignored.
// - rst asserted mid-frame: immediately returns to the reset values above. No partial-frame completion pulse is issued.
// CONFIGURATION
// - Macro PEAK_HOLD_EN.
// - Defined:
//   - A NUM_BINS x 4-bit peak array pk[] is kept, plus a global frame divider 0..PEAK_FALL-1 that advances at every DONE.
//   - In LOAD: if h>=pk[b], then pk[b]<=h. Otherwise, if the divider==PEAK_FALL-1, pk[b]<=pk[b]-1. Otherwise pk[b] is held.
//   - In EMIT: if pk>h and j==pk-1, the pixel is COLOR_PEAK; pk is the value before the LOAD update.
//   - The divider resets to 0.
// - Undefined: no peak storage and no COLOR_PEAK pixels; all other behaviour is identical.
// TESTING
// - All bins level 255, pix_ready=1, start pulse:
//   - 320 pixels; rows 0-5 COLOR_LOW, rows 6-7 COLOR_HIGH, odd bars in reversed row order.
//   - pix_last on pixel 319; frame_done 1 cycle later.
// - Bin 0=128, others 0: bar 0 = 4xCOLOR_LOW then 4x0; all other pixels are 0.
// - Backpressure: random pix_ready (50%):
//   - pix_data is stable while stalled; no pixel is lost or duplicated.
//   - The stream matches the no-stall reference sequence.
// - start pulses while busy: ignored; exactly one frame and one frame_done.
// - rst during bar 20: pix_valid=0 and busy=0 on assertion. A subsequent start yields a full frame from bin 0.
// - PEAK_HOLD_EN with bin 3:
//   - Bin 3=255 in frame 1, then 0. Frame 2 shows COLOR_PEAK at row 7.
//   - The marker drops one row every 4 frames and is gone once pk reaches 0.

Source files
------------

// File: rtl/spectrum_bar_renderer.sv
// Sweeps the spectrum filter bins on each start pulse and streams one GRB bar-graph frame.
// Optional peak-hold marker is built when the PEAK_HOLD_EN macro is defined.
`timescale 1ns/1ps
module spectrum_bar_renderer #(
    parameter int          NUM_BINS     = 40,
    parameter int          LEVEL_W      = 8,
    parameter int          LEDS_PER_BAR = 8,
    parameter bit          SERPENTINE   = 1'b1,
    parameter logic [23:0] COLOR_LOW    = 24'hFF0000,
    parameter logic [23:0] COLOR_HIGH   = 24'h00FF00,
    parameter logic [23:0] COLOR_PEAK   = 24'hFFFFFF,
    parameter int          PEAK_FALL    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [7:0]         bin_addr,
    input  logic [LEVEL_W-1:0] bin_level,
    output logic [23:0]        pix_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               pix_last,
    output logic               busy,
    output logic               frame_done
);

    if (LEDS_PER_BAR < 2 || LEDS_PER_BAR > 15 || NUM_BINS < 1 || NUM_BINS > 256 || PEAK_FALL < 1)
    begin : g_bad_params
        $error("spectrum_bar_renderer: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LOAD,
        S_EMIT,
        S_DONE
    } state_t;

    localparam int          PROD_W      = LEVEL_W + 4;
    localparam logic [7:0]  LAST_BIN    = 8'(NUM_BINS - 1);
    localparam logic [3:0]  LAST_PIX    = 4'(LEDS_PER_BAR - 1);
    localparam logic [5:0]  HIGH_THRESH = 6'(3 * LEDS_PER_BAR);

    state_t            state_q, state_d;
    logic [7:0]        b_q, b_d;
    logic [3:0]        p_q, p_d;
    logic [3:0]        h_q, h_d;
    logic [PROD_W-1:0] prod;
    logic [3:0]        h_calc;
    logic [3:0]        row;
    logic              lit;
    logic              high_zone;
    logic              peak_hit;
    logic              xfer;
    logic              bar_end;

    // Bar height in pixels; (level+1)*LEDS never overflows the 4 extra bits.
    always_comb begin
        prod   = ({4'b0000, bin_level} + PROD_W'(1)) * PROD_W'(LEDS_PER_BAR);
        h_calc = 4'(prod >> LEVEL_W);
    end

    always_comb begin
        row       = (SERPENTINE && b_q[0]) ? (LAST_PIX - p_q) : p_q;
        lit       = row < h_q;
        high_zone = {row, 2'b00} >= HIGH_THRESH;
        xfer      = (state_q == S_EMIT) && pix_ready;
        bar_end   = p_q == LAST_PIX;
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        p_d     = p_q;
        h_d     = h_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ADDR;
                    b_d     = '0;
                end
            end
            S_ADDR: state_d = S_LOAD;
            S_LOAD: begin
                h_d     = h_calc;
                p_d     = '0;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (xfer) begin
                    if (!bar_end) begin
                        p_d = p_q + 4'd1;
                    end else if (b_q == LAST_BIN) begin
                        state_d = S_DONE;
                    end else begin
                        b_d     = b_q + 8'd1;
                        state_d = S_ADDR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            b_q     <= '0;
            p_q     <= '0;
            h_q     <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            p_q     <= p_d;
            h_q     <= h_d;
        end
    end

`ifdef PEAK_HOLD_EN
    localparam int                DIV_W    = (PEAK_FALL > 1) ? $clog2(PEAK_FALL) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(PEAK_FALL - 1);

    logic [3:0]       pk_vec [NUM_BINS];
    logic [3:0]       pk_cur;
    logic [3:0]       pk_old_q, pk_old_d;
    logic [DIV_W-1:0] div_q, div_d;

    for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_pk
        logic [3:0] pk_q, pk_d;

        // Rise instantly to the new height; otherwise decay one pixel per PEAK_FALL frames.
        always_comb begin
            pk_d = pk_q;
            if (state_q == S_LOAD && b_q == 8'(gi)) begin
                if (h_calc >= pk_q) begin
                    pk_d = h_calc;
                end else if (div_q == DIV_LAST) begin
                    pk_d = pk_q - 4'd1;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pk_q <= '0;
            end else begin
                pk_q <= pk_d;
            end
        end

        assign pk_vec[gi] = pk_q;
    end

    always_comb begin
        pk_cur = '0;
        for (int i = 0; i < NUM_BINS; i++) begin
            if (b_q == 8'(i)) begin
                pk_cur = pk_vec[i];
            end
        end
    end

    // The marker shows the peak as it was before this frame's update.
    always_comb begin
        pk_old_d = (state_q == S_LOAD) ? pk_cur : pk_old_q;
        div_d    = div_q;
        if (state_q == S_DONE) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pk_old_q <= '0;
            div_q    <= '0;
        end else begin
            pk_old_q <= pk_old_d;
            div_q    <= div_d;
        end
    end

    assign peak_hit = (pk_old_q > h_q) && (row == pk_old_q - 4'd1);
`else
    assign peak_hit = 1'b0;
`endif

    always_comb begin
        pix_data = '0;
        if (state_q == S_EMIT) begin
            if (lit) begin
                pix_data = high_zone ? COLOR_HIGH : COLOR_LOW;
            end else if (peak_hit) begin
                pix_data = COLOR_PEAK;
            end
        end
    end

    assign bin_addr   = b_q;
    assign pix_valid  = state_q == S_EMIT;
    assign pix_last   = (state_q == S_EMIT) && (b_q == LAST_BIN) && bar_end;
    assign busy       = (state_q == S_ADDR) || (state_q == S_LOAD) || (state_q == S_EMIT);
    assign frame_done = state_q == S_DONE;

endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// Self-checking bench for spectrum_bar_renderer: frame table, backpressure, reset abort, peak hold.
`timescale 1ns/1ps
module tb_spectrum_bar_renderer;
    localparam int NB   = 40;
    localparam int LPB  = 8;
    localparam int PF   = 4;
    localparam int NPIX = NB * LPB;
    localparam int TMO  = 20000;
    localparam logic [23:0] C_LOW  = 24'hFF0000;
    localparam logic [23:0] C_HIGH = 24'h00FF00;
    localparam logic [23:0] C_PEAK = 24'hFFFFFF;

    logic        clk = 1'b0;
    logic        rst, start, pix_ready;
    logic [7:0]  bin_addr;
    logic [7:0]  bin_level;
    logic [23:0] pix_data;
    logic        pix_valid, pix_last, busy, frame_done;

    spectrum_bar_renderer dut (
        .clk(clk), .rst(rst), .start(start), .bin_addr(bin_addr), .bin_level(bin_level),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_last(pix_last), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] levels [256];
    always @(posedge clk) bin_level <= levels[bin_addr];
    always @(posedge clk) cyc <= cyc + 1;

    // Collector: accepted pixels, stall stability, frame_done pulses.
    logic [24:0] got_q [$];
    logic [24:0] exp_q [$];
    int  done_cnt = 0, done_cyc = -1, last_cyc = -1;
    bit  rand_ready = 1'b0;
    bit  stall_prev = 1'b0;
    logic [24:0] stall_val;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) chk("stall_hold", {7'd0, pix_valid, pix_last, pix_data}, {7'd0, 1'b1, stall_val});
                stall_prev = pix_valid && !pix_ready;
                stall_val  = {pix_last, pix_data};
                if (pix_valid && pix_ready) begin
                    got_q.push_back({pix_last, pix_data});
                    if (pix_last) last_cyc = cyc;
                end
                if (frame_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Reference model: bar heights and peak markers straight from the frame rules.
    int mpk [NB];
    int mdiv;

    task automatic model_reset();
        for (int b = 0; b < NB; b++) mpk[b] = 0;
        mdiv = 0;
    endtask

    task automatic model_frame();
        int h, pko, j;
        logic [23:0] px;
        exp_q.delete();
        for (int b = 0; b < NB; b++) begin
            h   = ((int'(levels[b]) + 1) * LPB) / 256;
            pko = mpk[b];
            if (h >= pko) mpk[b] = h;
            else if (mdiv == PF - 1) mpk[b] = pko - 1;
            for (int p = 0; p < LPB; p++) begin
                j  = (b % 2 == 1) ? (LPB - 1 - p) : p;
                px = 24'h0;
                if (j < h) px = (4 * j >= 3 * LPB) ? C_HIGH : C_LOW;
`ifdef PEAK_HOLD_EN
                else if (pko > h && j == pko - 1) px = C_PEAK;
`endif
                exp_q.push_back({(b == NB - 1 && p == LPB - 1), px});
            end
        end
        mdiv = (mdiv + 1) % PF;
    endtask

    task automatic run_frame(input string nm, input bit spam, input bit timing);
        int s, n;
        got_q.delete();
        done_cnt = 0; done_cyc = -1; last_cyc = -1;
        model_frame();
        @(posedge clk); #1;
        start = 1'b1; s = cyc;
        chk({nm, "_busy_idle"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, "_busy_rise"}, {31'd0, busy}, 32'd1);
        chk({nm, "_valid_addr"}, {31'd0, pix_valid}, 32'd0);
        n = 1;
        while (done_cnt == 0 && n < TMO) begin
            @(posedge clk); #1;
            n++;
            start = spam && (n % 97 == 50);
        end
        start = 1'b0;
        if (done_cnt == 0) begin
            total++; bad++;
            $display("FAIL %s_timeout got=no_frame_done want=frame_done", nm);
        end
        repeat (20) @(posedge clk);
        #1;
        chk({nm, "_one_done"}, done_cnt, 1);
        chk({nm, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_len"}, got_q.size(), NPIX);
        for (int i = 0; i < NPIX; i++) begin
            chk($sformatf("%s_px%0d", nm, i), {7'd0, (i < got_q.size()) ? got_q[i] : 25'hx}, {7'd0, exp_q[i]});
        end
        chk({nm, "_done_lat"}, done_cyc - last_cyc, 1);
        if (timing) chk({nm, "_cycles"}, done_cyc - s, NB * (LPB + 2) + 1);
    endtask

    task automatic spot(input string nm, input int idx, input logic [23:0] want);
        chk(nm, {8'd0, (idx < got_q.size()) ? got_q[idx][23:0] : 24'hx}, {8'd0, want});
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        string       name;
        int          mode;
        bit          rnd;
        bit          timing;
        int          idx [3];
        logic [23:0] px  [3];
    } vec_t;
    vec_t vecs [5];

    initial begin
        #800000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < 256; i++) levels[i] = 8'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, pix_valid}, 32'd0);
        chk("rst_data", {8'd0, pix_data}, 32'd0);
        chk("rst_last", {31'd0, pix_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_addr", {24'd0, bin_addr}, 32'd0);
        rst = 1'b0;

        vecs[0] = '{name: "bin0_half", mode: 0, rnd: 1'b0, timing: 1'b1,
                    idx: '{3, 4, 8}, px: '{C_LOW, 24'h0, 24'h0}};
        vecs[1] = '{name: "all_full", mode: 1, rnd: 1'b0, timing: 1'b1,
                    idx: '{5, 8, 319}, px: '{C_LOW, C_HIGH, C_LOW}};
        vecs[2] = '{name: "rand_go", mode: 2, rnd: 1'b0, timing: 1'b1,
                    idx: '{-1, -1, -1}, px: '{24'h0, 24'h0, 24'h0}};
        vecs[3] = '{name: "rand_stall", mode: 2, rnd: 1'b1, timing: 1'b0,
                    idx: '{-1, -1, -1}, px: '{24'h0, 24'h0, 24'h0}};
        vecs[4] = '{name: "start_spam", mode: 3, rnd: 1'b0, timing: 1'b1,
                    idx: '{-1, -1, -1}, px: '{24'h0, 24'h0, 24'h0}};

        for (int v = 0; v < 5; v++) begin
            for (int b = 0; b < NB; b++) begin
                case (vecs[v].mode)
                    0:       levels[b] = (b == 0) ? 8'd128 : 8'd0;
                    1:       levels[b] = 8'd255;
                    default: levels[b] = 8'($urandom_range(0, 255));
                endcase
            end
            rand_ready = vecs[v].rnd;
            run_frame(vecs[v].name, vecs[v].mode == 3, vecs[v].timing);
            rand_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (vecs[v].idx[k] >= 0) spot($sformatf("%s_spot%0d", vecs[v].name, k), vecs[v].idx[k], vecs[v].px[k]);
            end
        end

        // Abort a frame during bar 20, then expect a clean full frame.
        for (int b = 0; b < NB; b++) levels[b] = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(bin_addr == 8'd20 && pix_valid) && n < TMO) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= TMO) begin
            total++; bad++;
            $display("FAIL bar20_timeout got=no_bar20 want=bar20");
        end
        rst = 1'b1;
        #1;
        chk("abort_valid", {31'd0, pix_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_addr", {24'd0, bin_addr}, 32'd0);
        chk("abort_data", {8'd0, pix_data}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        done_cnt = 0;
        rst = 1'b0;
        model_reset();
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, 0);
        run_frame("after_rst", 1'b0, 1'b1);

`ifdef PEAK_HOLD_EN
        do_reset();
        for (int b = 0; b < NB; b++) levels[b] = 8'd0;
        levels[3] = 8'd255;
        run_frame("pk_f1", 1'b0, 1'b0);
        levels[3] = 8'd0;
        for (int f = 2; f <= 33; f++) begin
            run_frame($sformatf("pk_f%0d", f), 1'b0, 1'b0);
            if (f == 2)  spot("pk_row7", 24, C_PEAK);
            if (f == 5)  spot("pk_row6", 25, C_PEAK);
            if (f == 32) spot("pk_row0", 31, C_PEAK);
            if (f == 33) spot("pk_gone", 31, 24'h0);
        end
`else
        do_reset();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
